// File: rtl/core_setup_loader_pkg.sv
// core_setup_loader_pkg
//   Shared definitions for the boot/configuration sequencer: FSM state
//   encoding, default sizing and small state-decode helpers used both by the
//   RTL and by its testbench.
package core_setup_loader_pkg;

  // Sequencer states. Stream-consuming states are the two header states and
  // the two load states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_IMEM_HDR  = 3'd1,
    ST_IMEM_LOAD = 3'd2,
    ST_REG_HDR   = 3'd3,
    ST_REG_LOAD  = 3'd4,
    ST_LAUNCH    = 3'd5,
    ST_RUN       = 3'd6,
    ST_ERROR     = 3'd7
  } ldr_state_e;

  localparam int LDR_IMEM_WORDS = 1024;
  localparam int LDR_NUM_REGS   = 32;

  // States in which the loader accepts stream words.
  function automatic logic is_stream_state(input ldr_state_e s);
    return (s == ST_IMEM_HDR) || (s == ST_IMEM_LOAD) ||
           (s == ST_REG_HDR)  || (s == ST_REG_LOAD);
  endfunction

  // A sequence is in progress everywhere except the resting states.
  function automatic logic is_busy_state(input ldr_state_e s);
    return !((s == ST_IDLE) || (s == ST_RUN) || (s == ST_ERROR));
  endfunction

endpackage

// File: rtl/core_setup_loader.sv
// core_setup_loader
//   Boot/configuration sequencer. Consumes a valid/ready word stream of the
//   form  N, instr[0..N-1], M, reg[1..M]  and drives the core's instruction
//   memory and register-file load ports, then presents the start PC and
//   releases the core from setup mode.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_start             begin a load sequence (IDLE/RUN/ERROR only)
//   i_boot_addr         start PC, sampled with i_start
//   i_s_valid/i_s_data  stream word in;  o_s_ready  loader accepts a word
//   o_setup             core held in setup mode
//   o_inst_mem_*        instruction-memory write port (byte address)
//   o_load_reg_*        register-file load port (x1..xM)
//   o_pc_start_addr     start PC to the core
//   o_busy, o_done, o_err  status: in progress, release pulse, sticky error
module core_setup_loader
  import core_setup_loader_pkg::*;
#(
  parameter int IMEM_WORDS = LDR_IMEM_WORDS,
  parameter int NUM_REGS   = LDR_NUM_REGS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_boot_addr,
  input  logic        i_s_valid,
  input  logic [31:0] i_s_data,
  output logic        o_s_ready,
  output logic        o_setup,
  output logic        o_inst_mem_we,
  output logic [31:0] o_inst_mem_addr,
  output logic [31:0] o_inst_mem_data,
  output logic        o_load_reg_we,
  output logic [4:0]  o_load_reg_addr,
  output logic [31:0] o_load_reg_data,
  output logic [31:0] o_pc_start_addr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  // Counter must be able to hold N itself (up to IMEM_WORDS).
  localparam int CNT_W = $clog2(IMEM_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ldr_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, n_words, n_words_nxt;
  logic [4:0]       idx, idx_nxt, n_regs, n_regs_nxt;
  logic [31:0]      boot, boot_nxt;
  logic             xfer;

  logic             inst_we_nxt, reg_we_nxt, done_nxt, err_nxt;
  logic [31:0]      inst_addr_nxt, inst_data_nxt, reg_data_nxt, pc_nxt;
  logic [4:0]       reg_addr_nxt;

  assign xfer = i_s_valid & o_s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      n_words <= '0;
      idx     <= '0;
      n_regs  <= '0;
      boot    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      n_words <= n_words_nxt;
      idx     <= idx_nxt;
      n_regs  <= n_regs_nxt;
      boot    <= boot_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    n_words_nxt   = n_words;
    idx_nxt       = idx;
    n_regs_nxt    = n_regs;
    boot_nxt      = boot;
    inst_we_nxt   = 1'b0;
    inst_addr_nxt = o_inst_mem_addr;
    inst_data_nxt = o_inst_mem_data;
    reg_we_nxt    = 1'b0;
    reg_addr_nxt  = o_load_reg_addr;
    reg_data_nxt  = o_load_reg_data;
    pc_nxt        = o_pc_start_addr;
    done_nxt      = 1'b0;
    err_nxt       = o_err;

    case (state)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (i_start) begin
          state_nxt = ST_IMEM_HDR;
          boot_nxt  = i_boot_addr;
          err_nxt   = 1'b0;
        end
      end
      ST_IMEM_HDR: begin
        if (xfer) begin
          if (i_s_data > 32'(IMEM_WORDS)) begin
            state_nxt = ST_ERROR;
          end else if (i_s_data == 32'd0) begin
            state_nxt = ST_REG_HDR;
          end else begin
            state_nxt   = ST_IMEM_LOAD;
            cnt_nxt     = '0;
            n_words_nxt = i_s_data[CNT_W-1:0];
          end
        end
      end
      ST_IMEM_LOAD: begin
        if (xfer) begin
          inst_we_nxt   = 1'b1;
          inst_addr_nxt = 32'({cnt, 2'b00});
          inst_data_nxt = i_s_data;
          cnt_nxt       = cnt + CNT_ONE;
          if (cnt == n_words - CNT_ONE) state_nxt = ST_REG_HDR;
        end
      end
      ST_REG_HDR: begin
        if (xfer) begin
          if (i_s_data > 32'(NUM_REGS - 1)) begin
            state_nxt = ST_ERROR;
          end else if (i_s_data == 32'd0) begin
            state_nxt = ST_LAUNCH;
          end else begin
            state_nxt  = ST_REG_LOAD;
            idx_nxt    = 5'd1;
            n_regs_nxt = i_s_data[4:0];
          end
        end
      end
      ST_REG_LOAD: begin
        if (xfer) begin
          reg_we_nxt   = 1'b1;
          reg_addr_nxt = idx;
          reg_data_nxt = i_s_data;
          idx_nxt      = idx + 5'd1;
          if (idx == n_regs) state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // A misaligned start PC would fault the core on its first fetch.
        if (boot[1:0] != 2'b00) begin
          state_nxt = ST_ERROR;
        end else begin
          state_nxt = ST_RUN;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // PC is presented during LAUNCH and held afterwards.
    if (state_nxt == ST_LAUNCH) pc_nxt = boot;
    if (state_nxt == ST_ERROR)  err_nxt = 1'b1;
  end

  // Output register stage: status flags are decodes of the next state so they
  // line up with the state register; strobes carry the accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_s_ready       <= 1'b0;
      o_setup         <= 1'b1;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
      o_inst_mem_we   <= 1'b0;
      o_inst_mem_addr <= '0;
      o_inst_mem_data <= '0;
      o_load_reg_we   <= 1'b0;
      o_load_reg_addr <= '0;
      o_load_reg_data <= '0;
      o_pc_start_addr <= '0;
    end else begin
      o_s_ready       <= is_stream_state(state_nxt);
      o_setup         <= (state_nxt != ST_RUN);
      o_busy          <= is_busy_state(state_nxt);
      o_done          <= done_nxt;
      o_err           <= err_nxt;
      o_inst_mem_we   <= inst_we_nxt;
      o_inst_mem_addr <= inst_addr_nxt;
      o_inst_mem_data <= inst_data_nxt;
      o_load_reg_we   <= reg_we_nxt;
      o_load_reg_addr <= reg_addr_nxt;
      o_load_reg_data <= reg_data_nxt;
      o_pc_start_addr <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_core_setup_loader.sv
// tb_core_setup_loader
//   Scoreboard bench for core_setup_loader. Stimulus tasks push expected
//   instruction writes, register writes and release PCs into queues; a
//   negedge monitor pops and compares whenever the DUT strobes.
module tb_core_setup_loader;
  import core_setup_loader_pkg::*;

  localparam int IW = LDR_IMEM_WORDS;
  localparam int NR = LDR_NUM_REGS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_boot_addr = '0;
  logic        i_s_valid = 1'b0;
  logic [31:0] i_s_data = '0;
  logic        o_s_ready, o_setup, o_inst_mem_we, o_load_reg_we;
  logic [31:0] o_inst_mem_addr, o_inst_mem_data, o_load_reg_data, o_pc_start_addr;
  logic [4:0]  o_load_reg_addr;
  logic        o_busy, o_done, o_err;

  core_setup_loader dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_boot_addr(i_boot_addr),
    .i_s_valid(i_s_valid), .i_s_data(i_s_data), .o_s_ready(o_s_ready),
    .o_setup(o_setup), .o_inst_mem_we(o_inst_mem_we),
    .o_inst_mem_addr(o_inst_mem_addr), .o_inst_mem_data(o_inst_mem_data),
    .o_load_reg_we(o_load_reg_we), .o_load_reg_addr(o_load_reg_addr),
    .o_load_reg_data(o_load_reg_data), .o_pc_start_addr(o_pc_start_addr),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         inst_q[$];
  wr_t         reg_q[$];
  logic [31:0] done_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_inst_mem_we) begin
        if (inst_q.size() == 0) chk("unexpected_inst_we", 32'd1, 32'd0);
        else begin
          wr_t e;
          e = inst_q.pop_front();
          chk("inst_addr", o_inst_mem_addr, e.a);
          chk("inst_data", o_inst_mem_data, e.d);
        end
      end
      if (o_load_reg_we) begin
        if (reg_q.size() == 0) chk("unexpected_reg_we", 32'd1, 32'd0);
        else begin
          wr_t e;
          e = reg_q.pop_front();
          chk("reg_addr", 32'(o_load_reg_addr), e.a);
          chk("reg_data", o_load_reg_data, e.d);
        end
      end
      if (o_done) begin
        if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          logic [31:0] pc;
          pc = done_q.pop_front();
          chk("done_pc", o_pc_start_addr, pc);
          chk("done_setup", 32'(o_setup), 32'd0);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the word was taken.
  task automatic send(input logic [31:0] w, input bit gap);
    int t = 0;
    i_s_valid = 1'b1;
    i_s_data  = w;
    while (!o_s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!o_s_ready) chk("ready_timeout", 32'(o_s_ready), 32'd1);
    @(negedge clk);
    i_s_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic do_start(input logic [31:0] boot);
    i_start     = 1'b1;
    i_boot_addr = boot;
    @(negedge clk);
    i_start = 1'b0;
    chk("start_err_clear", 32'(o_err), 32'd0);
    chk("start_ready", 32'(o_s_ready), 32'd1);
    chk("start_busy", 32'(o_busy), 32'd1);
  endtask

  task automatic check_error_state(input string tag);
    chk({tag, "_err"}, 32'(o_err), 32'd1);
    chk({tag, "_ready"}, 32'(o_s_ready), 32'd0);
    chk({tag, "_setup"}, 32'(o_setup), 32'd1);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  function automatic bit pick_gap(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return bit'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  // Full sequence from the reference rules: N instructions at byte addresses
  // 4*i, M registers x1..xM, then release at boot unless boot is misaligned.
  task automatic load(input logic [31:0] boot, input int n, input int m, input int gmode);
    logic [31:0] w;
    bit          exp_err;
    int          t;
    do_start(boot);
    send(32'(n), pick_gap(gmode));
    if (n > IW) begin
      check_error_state("imem_hdr");
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      inst_q.push_back('{a: 32'(i * 4), d: w});
      send(w, pick_gap(gmode));
    end
    send(32'(m), (m > 0) ? pick_gap(gmode) : 1'b0);
    if (m > NR - 1) begin
      check_error_state("reg_hdr");
      return;
    end
    for (int i = 1; i <= m; i++) begin
      w = $urandom;
      reg_q.push_back('{a: 32'(i), d: w});
      send(w, (i < m) ? pick_gap(gmode) : 1'b0);
    end
    // Now in the single LAUNCH cycle.
    chk("launch_pc", o_pc_start_addr, boot);
    chk("launch_setup", 32'(o_setup), 32'd1);
    chk("launch_ready", 32'(o_s_ready), 32'd0);
    exp_err = (boot[1:0] != 2'b00);
    if (!exp_err) done_q.push_back(boot);
    t = 0;
    while (!(o_done || o_err) && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("launch_outcome_err", 32'(o_err), 32'(exp_err));
    if (exp_err) begin
      check_error_state("launch");
    end else begin
      chk("launch_done_seen", 32'(o_done), 32'd1);
      @(negedge clk);
      chk("done_single", 32'(o_done), 32'd0);
      chk("run_setup", 32'(o_setup), 32'd0);
      chk("run_pc_hold", o_pc_start_addr, boot);
      chk("run_busy", 32'(o_busy), 32'd0);
    end
    chk("inst_q_drained", 32'(inst_q.size()), 32'd0);
    chk("reg_q_drained", 32'(reg_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] boot;
    int          n, m;

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_setup", 32'(o_setup), 32'd1);
    chk("rst_ready", 32'(o_s_ready), 32'd0);
    chk("rst_inst_we", 32'(o_inst_mem_we), 32'd0);
    chk("rst_reg_we", 32'(o_load_reg_we), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_pc", o_pc_start_addr, 32'd0);

    // Back-to-back, then alternating-gap streams.
    load(32'h100, 3, 2, 0);
    load(32'h100, 3, 2, 1);

    // Oversized instruction count, then recovery by i_start.
    load(32'h100, IW + 1, 0, 0);
    // Oversized register count.
    load(32'h40, 1, NR, 0);

    // Empty sections: misaligned boot faults, aligned boot runs.
    load(32'h102, 0, 0, 0);
    load(32'h200, 0, 0, 0);

    // Largest register section.
    load(32'h0, 2, NR - 1, 2);

    // Randomized sequences.
    for (int k = 0; k < 8; k++) begin
      n    = $urandom_range(0, 10);
      m    = $urandom_range(0, NR - 1);
      boot = $urandom & 32'h0000_fffc;
      if ($urandom_range(0, 3) == 0) boot[1:0] = 2'($urandom_range(1, 3));
      load(boot, n, m, $urandom_range(0, 2));
    end

    // Asynchronous reset after the second instruction write.
    do_start(32'h300);
    send(32'd5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      inst_q.push_back('{a: 32'(i * 4), d: w});
      i_s_valid = 1'b1;
      i_s_data  = w;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_setup", 32'(o_setup), 32'd1);
    chk("arst_ready", 32'(o_s_ready), 32'd0);
    chk("arst_inst_we", 32'(o_inst_mem_we), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_writes_seen", 32'(inst_q.size()), 32'd0);
    i_s_valid = 1'b0;
    inst_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(32'h300, 4, 3, 0);

    chk("final_done_q", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
